engine_rpm_model: RTL and testbench



---
 rtl/drag_pkg.sv | 49 ++++
 rtl/rpm_rescale.sv | 42 ++++
 rtl/engine_rpm_model.sv | 184 ++++++++++++++++++
 tb/tb_engine_rpm_model.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/drag_pkg.sv
// ============================================================================
// Module  : drag_pkg
// Brief   : Shared drivetrain constants for the engine and velocity stages.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package drag_pkg;

    // Gear ratios; the velocity stage uses the same table.
    localparam logic [4:0] RATIO_G0 = 5'd9;
    localparam logic [4:0] RATIO_G1 = 5'd13;
    localparam logic [4:0] RATIO_G2 = 5'd18;
    localparam logic [4:0] RATIO_G3 = 5'd25;

    localparam logic [1:0] GEAR_0 = 2'd0;
    localparam logic [1:0] GEAR_1 = 2'd1;
    localparam logic [1:0] GEAR_2 = 2'd2;
    localparam logic [1:0] GEAR_3 = 2'd3;

    // RPM rescale factors in 1/256 units (old ratio / new ratio).
    localparam logic [8:0] K_UP_0_1 = 9'd177;
    localparam logic [8:0] K_UP_1_2 = 9'd184;
    localparam logic [8:0] K_UP_2_3 = 9'd184;
    localparam logic [8:0] K_DN_1_0 = 9'd369;
    localparam logic [8:0] K_DN_2_1 = 9'd354;
    localparam logic [8:0] K_DN_3_2 = 9'd355;

    typedef enum logic [1:0] {
        ST_STANDBY = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_SHIFT   = 2'd2
    } engine_state_e;

    function automatic logic [8:0] rescale_k(input logic [1:0] gear, input logic up);
        case ({up, gear})
            {1'b1, GEAR_0}: rescale_k = K_UP_0_1;
            {1'b1, GEAR_1}: rescale_k = K_UP_1_2;
            {1'b1, GEAR_2}: rescale_k = K_UP_2_3;
            {1'b0, GEAR_1}: rescale_k = K_DN_1_0;
            {1'b0, GEAR_2}: rescale_k = K_DN_2_1;
            {1'b0, GEAR_3}: rescale_k = K_DN_3_2;
            default:        rescale_k = 9'd256;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rpm_rescale.sv
// ============================================================================
// Module  : rpm_rescale
// Brief   : Combinational gear-change RPM rescale: (rpm * K) >> 8, clamped.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rpm_rescale
    import drag_pkg::*;
#(
    parameter int RPM_IDLE = 800,
    parameter int RPM_MAX  = 8000
) (
    input  logic [13:0] i_rpm,
    input  logic [1:0]  i_gear,
    input  logic        i_dir,
    output logic [13:0] o_rpm
);

    localparam logic [14:0] c_idle = 15'(RPM_IDLE);
    localparam logic [14:0] c_max  = 15'(RPM_MAX);

    logic [8:0]  w_k;
    logic [22:0] w_prod;
    logic [14:0] w_scaled;

    always_comb begin
        w_k      = rescale_k(i_gear, i_dir);
        w_prod   = {9'd0, i_rpm} * {14'd0, w_k};
        w_scaled = 15'(w_prod >> 8);
        if (w_scaled < c_idle) begin
            o_rpm = c_idle[13:0];
        end else if (w_scaled > c_max) begin
            o_rpm = c_max[13:0];
        end else begin
            o_rpm = w_scaled[13:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/engine_rpm_model.sv
// ============================================================================
// Module  : engine_rpm_model
// Brief   : Per-tick engine RPM/gear model with shift lockout and ceiling.
//           Optional rev limiter enabled by defining REV_LIMITER_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module engine_rpm_model
    import drag_pkg::*;
#(
    parameter int RPM_IDLE    = 800,
    parameter int RPM_MAX     = 8000,
    parameter int RPM_ACCEL   = 64,
    parameter int RPM_DECEL   = 48,
    parameter int SHIFT_TICKS = 20,
    parameter int RPM_CUT     = 400,
    parameter int LIMIT_TICKS = 10
) (
    input  logic        clk100Hz,
    input  logic        rst,
    input  logic        throttle,
    input  logic        shift_up,
    input  logic        shift_down,
    input  logic        race_go,
    input  logic        reset_status,
    output logic [13:0] rpm,
    output logic [1:0]  gear,
    output logic        shifting,
    output logic        limiter_active
);

    localparam int          c_shift_w    = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
    localparam logic [c_shift_w-1:0] c_shift_last = c_shift_w'(SHIFT_TICKS - 1);
    localparam logic [13:0] c_idle14  = 14'(RPM_IDLE);
    localparam logic [13:0] c_max14   = 14'(RPM_MAX);
    localparam logic [13:0] c_decel14 = 14'(RPM_DECEL);
    localparam logic [14:0] c_max15   = 15'(RPM_MAX);
    localparam logic [14:0] c_floor15 = 15'(RPM_IDLE + RPM_DECEL);
    localparam logic [14:0] c_accel15 = 15'(RPM_ACCEL);

    engine_state_e          state_q, state_d;
    logic [13:0]            rpm_q, rpm_d;
    logic [1:0]             gear_q, gear_d;
    logic [c_shift_w-1:0]   cnt_q, cnt_d;
    logic                   su_q, su_d, sd_q, sd_d;
    logic                   shifting_q, shifting_d;

    logic                   w_up_edge, w_dn_edge, w_up_ok, w_dn_ok, w_thr;
    logic [14:0]            w_step, w_sum;
    logic [13:0]            w_rescaled;

`ifdef REV_LIMITER_EN
    localparam int          c_lim_w = $clog2(LIMIT_TICKS + 1);
    logic [c_lim_w-1:0]     lim_cnt_q, lim_cnt_d;
    logic                   limiter_active_q, limiter_active_d;
`else
    logic                   w_unused_cfg;
    assign w_unused_cfg = ^{RPM_CUT, LIMIT_TICKS};
`endif

    rpm_rescale #(
        .RPM_IDLE (RPM_IDLE),
        .RPM_MAX  (RPM_MAX)
    ) u_rescale (
        .i_rpm  (rpm_q),
        .i_gear (gear_q),
        .i_dir  (w_up_ok),
        .o_rpm  (w_rescaled)
    );

    // Both edges together cancel; out-of-range shifts are dropped without lockout.
    always_comb begin
        w_up_edge = shift_up & ~su_q;
        w_dn_edge = shift_down & ~sd_q;
        w_up_ok   = (state_q == ST_DRIVE) && w_up_edge && !w_dn_edge && (gear_q != GEAR_3);
        w_dn_ok   = (state_q == ST_DRIVE) && w_dn_edge && !w_up_edge && (gear_q != GEAR_0);
        w_step    = c_accel15 >> gear_q;
        w_sum     = {1'b0, rpm_q} + w_step;
`ifdef REV_LIMITER_EN
        w_thr     = throttle && (state_q != ST_SHIFT) && (lim_cnt_q == '0);
`else
        w_thr     = throttle && (state_q != ST_SHIFT);
`endif
    end

    always_comb begin
        state_d = state_q;
        rpm_d   = rpm_q;
        gear_d  = gear_q;
        cnt_d   = cnt_q;
        su_d    = shift_up;
        sd_d    = shift_down;
`ifdef REV_LIMITER_EN
        lim_cnt_d = (lim_cnt_q != '0) ? lim_cnt_q - 1'b1 : '0;
`endif

        case (state_q)
            ST_STANDBY: if (race_go) state_d = ST_DRIVE;
            ST_DRIVE: begin
                if (w_up_ok || w_dn_ok) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == c_shift_last) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_STANDBY;
        endcase

        if (w_up_ok || w_dn_ok) begin
            rpm_d  = w_rescaled;
            gear_d = w_up_ok ? gear_q + 2'd1 : gear_q - 2'd1;
        end else if (w_thr) begin
            if (w_sum >= c_max15) begin
`ifdef REV_LIMITER_EN
                rpm_d     = 14'(RPM_MAX - RPM_CUT);
                lim_cnt_d = c_lim_w'(LIMIT_TICKS);
`else
                rpm_d     = c_max14;
`endif
            end else begin
                rpm_d = w_sum[13:0];
            end
        end else if ({1'b0, rpm_q} < c_floor15) begin
            rpm_d = c_idle14;
        end else begin
            rpm_d = rpm_q - c_decel14;
        end

        shifting_d = (state_d == ST_SHIFT);
`ifdef REV_LIMITER_EN
        limiter_active_d = (lim_cnt_d != '0);
`endif
    end

    always_ff @(posedge clk100Hz) begin
        if (rst || reset_status) begin
            state_q    <= ST_STANDBY;
            rpm_q      <= c_idle14;
            gear_q     <= GEAR_0;
            cnt_q      <= '0;
            su_q       <= 1'b0;
            sd_q       <= 1'b0;
            shifting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rpm_q      <= rpm_d;
            gear_q     <= gear_d;
            cnt_q      <= cnt_d;
            su_q       <= su_d;
            sd_q       <= sd_d;
            shifting_q <= shifting_d;
        end
    end

`ifdef REV_LIMITER_EN
    always_ff @(posedge clk100Hz) begin
        if (rst || reset_status) begin
            lim_cnt_q        <= '0;
            limiter_active_q <= 1'b0;
        end else begin
            lim_cnt_q        <= lim_cnt_d;
            limiter_active_q <= limiter_active_d;
        end
    end
    assign limiter_active = limiter_active_q;
`else
    assign limiter_active = 1'b0;
`endif

    assign rpm      = rpm_q;
    assign gear     = gear_q;
    assign shifting = shifting_q;

endmodule

`default_nettype wire

// File: tb/tb_engine_rpm_model.sv
// ============================================================================
// Module  : tb_engine_rpm_model
// Brief   : Directed self-checking bench for engine_rpm_model (REV_LIMITER_EN aware).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_engine_rpm_model;

    logic        clk100Hz = 1'b0;
    logic        rst = 1'b1, throttle = 1'b0, shift_up = 1'b0, shift_down = 1'b0;
    logic        race_go = 1'b0, reset_status = 1'b0;
    logic [13:0] rpm;
    logic [1:0]  gear;
    logic        shifting, limiter_active;

    int checks = 0;
    int errors = 0;

    engine_rpm_model dut (
        .clk100Hz       (clk100Hz),
        .rst            (rst),
        .throttle       (throttle),
        .shift_up       (shift_up),
        .shift_down     (shift_down),
        .race_go        (race_go),
        .reset_status   (reset_status),
        .rpm            (rpm),
        .gear           (gear),
        .shifting       (shifting),
        .limiter_active (limiter_active)
    );

    always #5 clk100Hz = ~clk100Hz;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk100Hz);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; throttle = 1'b0; shift_up = 1'b0; shift_down = 1'b0; race_go = 1'b0;
        tick(2);
        rst = 1'b0;
        checks++; if (rpm !== 14'd800) begin errors++; $display("FAIL reset_rpm got %0d exp 800", rpm); end
        checks++; if (gear !== 2'd0) begin errors++; $display("FAIL reset_gear got %0d exp 0", gear); end
        checks++; if (shifting !== 1'b0) begin errors++; $display("FAIL reset_shifting got %0b exp 0", shifting); end
        checks++; if (limiter_active !== 1'b0) begin errors++; $display("FAIL reset_limiter got %0b exp 0", limiter_active); end
    endtask

    task automatic test_throttle;
        throttle = 1'b1;
        tick(10);
        checks++; if (rpm !== 14'd1440) begin errors++; $display("FAIL thr10_rpm got %0d exp 1440", rpm); end
        throttle = 1'b0;
        tick(1);
        checks++; if (rpm !== 14'd1392) begin errors++; $display("FAIL decel_rpm got %0d exp 1392", rpm); end
    endtask

    task automatic test_upshift;
        rst = 1'b1; tick(1); rst = 1'b0;
        race_go = 1'b1; throttle = 1'b1;
        tick(89);
        throttle = 1'b0;
        tick(2);
        checks++; if (rpm !== 14'd6400) begin errors++; $display("FAIL up_pre_rpm got %0d exp 6400", rpm); end
        shift_up = 1'b1;
        tick(1);
        checks++; if (gear !== 2'd1) begin errors++; $display("FAIL up_gear got %0d exp 1", gear); end
        checks++; if (rpm !== 14'd4425) begin errors++; $display("FAIL up_rpm got %0d exp 4425", rpm); end
        checks++; if (shifting !== 1'b1) begin errors++; $display("FAIL up_shifting got %0b exp 1", shifting); end
        shift_up = 1'b0; tick(1);
        shift_up = 1'b1; tick(1);
        checks++; if (gear !== 2'd1) begin errors++; $display("FAIL lockout_gear got %0d exp 1", gear); end
        tick(17);
        checks++; if (shifting !== 1'b1) begin errors++; $display("FAIL lockout_end_hi got %0b exp 1", shifting); end
        checks++; if (rpm !== 14'd3513) begin errors++; $display("FAIL lockout_rpm got %0d exp 3513", rpm); end
        tick(1);
        checks++; if (shifting !== 1'b0) begin errors++; $display("FAIL lockout_release got %0b exp 0", shifting); end
        checks++; if (rpm !== 14'd3465) begin errors++; $display("FAIL release_rpm got %0d exp 3465", rpm); end
        checks++; if (gear !== 2'd1) begin errors++; $display("FAIL release_gear got %0d exp 1", gear); end
    endtask

    task automatic test_downshift;
        shift_up = 1'b0;
        tick(60);
        checks++; if (rpm !== 14'd800) begin errors++; $display("FAIL idle_floor got %0d exp 800", rpm); end
        throttle = 1'b1; tick(164);
        throttle = 1'b0; tick(1);
        checks++; if (rpm !== 14'd6000) begin errors++; $display("FAIL g1_rpm got %0d exp 6000", rpm); end
        shift_down = 1'b1;
        tick(1);
        checks++; if (gear !== 2'd0) begin errors++; $display("FAIL dn_gear got %0d exp 0", gear); end
        checks++; if (rpm !== 14'd8000) begin errors++; $display("FAIL dn_rpm_clamp got %0d exp 8000", rpm); end
        checks++; if (shifting !== 1'b1) begin errors++; $display("FAIL dn_shifting got %0b exp 1", shifting); end
        tick(20);
        checks++; if (rpm !== 14'd7040) begin errors++; $display("FAIL dn_decay got %0d exp 7040", rpm); end
        shift_down = 1'b0; tick(1);
        shift_up = 1'b1; shift_down = 1'b1; tick(1);
        checks++; if (gear !== 2'd0) begin errors++; $display("FAIL both_gear got %0d exp 0", gear); end
        checks++; if (shifting !== 1'b0) begin errors++; $display("FAIL both_shifting got %0b exp 0", shifting); end
        checks++; if (rpm !== 14'd6944) begin errors++; $display("FAIL both_rpm got %0d exp 6944", rpm); end
        shift_up = 1'b0; shift_down = 1'b0; tick(1);
        shift_down = 1'b1; tick(1);
        checks++; if (gear !== 2'd0 || shifting !== 1'b0) begin errors++; $display("FAIL dn_g0_ignored gear %0d shifting %0b exp 0 0", gear, shifting); end
        checks++; if (rpm !== 14'd6848) begin errors++; $display("FAIL dn_g0_rpm got %0d exp 6848", rpm); end
    endtask

    task automatic test_ceiling;
        throttle = 1'b1;
        tick(18);
`ifdef REV_LIMITER_EN
        checks++; if (rpm !== 14'd7600) begin errors++; $display("FAIL lim_cut_rpm got %0d exp 7600", rpm); end
        checks++; if (limiter_active !== 1'b1) begin errors++; $display("FAIL lim_on got %0b exp 1", limiter_active); end
        tick(9);
        checks++; if (rpm !== 14'd7168) begin errors++; $display("FAIL lim_decay got %0d exp 7168", rpm); end
        checks++; if (limiter_active !== 1'b1) begin errors++; $display("FAIL lim_hold got %0b exp 1", limiter_active); end
        tick(1);
        checks++; if (limiter_active !== 1'b0) begin errors++; $display("FAIL lim_off got %0b exp 0", limiter_active); end
        checks++; if (rpm !== 14'd7120) begin errors++; $display("FAIL lim_last_rpm got %0d exp 7120", rpm); end
        tick(1);
        checks++; if (rpm !== 14'd7184) begin errors++; $display("FAIL lim_resume got %0d exp 7184", rpm); end
`else
        checks++; if (rpm !== 14'd8000) begin errors++; $display("FAIL ceil_rpm got %0d exp 8000", rpm); end
        tick(3);
        checks++; if (rpm !== 14'd8000) begin errors++; $display("FAIL ceil_hold got %0d exp 8000", rpm); end
        checks++; if (limiter_active !== 1'b0) begin errors++; $display("FAIL ceil_lim got %0b exp 0", limiter_active); end
`endif
        throttle = 1'b0; shift_down = 1'b0;
    endtask

    task automatic test_standby;
        rst = 1'b1; race_go = 1'b0; tick(1); rst = 1'b0;
        throttle = 1'b1;
        tick(10);
        checks++; if (rpm !== 14'd1440) begin errors++; $display("FAIL sb_rev got %0d exp 1440", rpm); end
        shift_up = 1'b1; tick(1);
        checks++; if (gear !== 2'd0 || shifting !== 1'b0) begin errors++; $display("FAIL sb_shift_ignored gear %0d shifting %0b exp 0 0", gear, shifting); end
        checks++; if (rpm !== 14'd1504) begin errors++; $display("FAIL sb_rpm got %0d exp 1504", rpm); end
        race_go = 1'b1; shift_up = 1'b0; throttle = 1'b0; tick(1);
        shift_up = 1'b1; tick(1);
        checks++; if (gear !== 2'd1 || shifting !== 1'b1) begin errors++; $display("FAIL go_shift gear %0d shifting %0b exp 1 1", gear, shifting); end
        checks++; if (rpm !== 14'd1006) begin errors++; $display("FAIL go_rpm got %0d exp 1006", rpm); end
        tick(1);
        reset_status = 1'b1; tick(1);
        checks++; if (rpm !== 14'd800 || gear !== 2'd0 || shifting !== 1'b0) begin errors++; $display("FAIL restart rpm %0d gear %0d shifting %0b exp 800 0 0", rpm, gear, shifting); end
        reset_status = 1'b0; race_go = 1'b0; shift_up = 1'b0; tick(1);
        shift_up = 1'b1; tick(1);
        checks++; if (gear !== 2'd0 || shifting !== 1'b0) begin errors++; $display("FAIL restart_standby gear %0d shifting %0b exp 0 0", gear, shifting); end
        shift_up = 1'b0;
    endtask

    initial begin
        test_reset();
        test_throttle();
        test_upshift();
        test_downshift();
        test_ceiling();
        test_standby();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
